// File: rtl/seg7_msg_sequencer_pkg.sv
// Shared types and constants for the 7-segment message sequencer.
package seg7_msg_sequencer_pkg;

  // Message sources. Each encoding is also the index of its source.
  typedef enum logic [2:0] {
    MSG_EMPTY = 3'd0,
    MSG_READY = 3'd1,
    MSG_RUN   = 3'd2,
    MSG_PAUSE = 3'd3,
    MSG_DONE  = 3'd4
  } msg_t;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_BLINK  = 1'b1
  } seg_mode_t;

  typedef enum logic {
    StShow = 1'b0,
    StWipe = 1'b1
  } seg_seq_state_t;

  // Active-low segments: all ones is a dark digit.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_msg_sequencer_if.sv
// Connection between the game-control side and the message sequencer.
interface seg7_msg_sequencer_if
  import seg7_msg_sequencer_pkg::*;
#(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned N_MSG  = 5
);
  localparam int unsigned MsgW = (N_MSG > 1) ? $clog2(N_MSG) : 1;

  logic [MsgW-1:0]                   msg_i;
  seg_mode_t                         mode_i;
  logic                              wipe_en_i;
  logic [N_MSG-1:0][DIGITS-1:0][7:0] seg_i;
  logic [DIGITS-1:0][7:0]            seg_o;
  logic                              busy_o;

  modport master (
    output msg_i, mode_i, wipe_en_i, seg_i,
    input  seg_o, busy_o
  );

  modport slave (
    input  msg_i, mode_i, wipe_en_i, seg_i,
    output seg_o, busy_o
  );

endinterface

// File: rtl/seg7_tick_gen.sv
// Prescaler emitting a one-cycle tick on the cycle it wraps from DIV-1 to 0.
module seg7_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over counting; a cleared cycle never ticks.
  always_comb begin
    tick_o = en_i && !clr_i && (cnt_q == CntW'(DIV - 1));
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_msg_sequencer.sv
// Selects one of N_MSG live segment sources for the display, with an optional
// left-to-right wipe on message change and an overlaid blink mode.
module seg7_msg_sequencer
  import seg7_msg_sequencer_pkg::*;
#(
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned N_MSG        = 5,
  parameter int unsigned WIPE_CYCLES  = 5_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000,
  parameter logic [7:0]  BLANK        = SEG_BLANK
) (
  input logic                 clk_i,
  input logic                 rst_i,
  seg7_msg_sequencer_if.slave bus
);
  localparam int unsigned MsgW = (N_MSG > 1) ? $clog2(N_MSG) : 1;
  localparam int unsigned KW   = $clog2(DIGITS + 1);

  seg_seq_state_t         state_q, state_d;
  logic [MsgW-1:0]        cur_q, cur_d;
  logic [MsgW-1:0]        prev_q, prev_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   phase_q, phase_d;
  seg_mode_t              mode_q;
  logic [DIGITS-1:0][7:0] seg_q, seg_d;
  logic                   busy_q;

  logic [MsgW-1:0] msg_san;
  logic            changed;
  logic            blink_clr;
  logic            wipe_tick;
  logic            blink_tick;

  // Out-of-range indices fall back to the empty message.
  always_comb begin
    msg_san   = (32'(bus.msg_i) < N_MSG) ? bus.msg_i : '0;
    changed   = (msg_san != cur_q);
    blink_clr = changed || ((bus.mode_i == MODE_BLINK) && (mode_q == MODE_STATIC));
  end

  seg7_tick_gen #(
    .DIV (WIPE_CYCLES)
  ) u_wipe_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == StWipe),
    .clr_i  (changed),
    .tick_o (wipe_tick)
  );

  seg7_tick_gen #(
    .DIV (BLINK_CYCLES)
  ) u_blink_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .clr_i  (blink_clr),
    .tick_o (blink_tick)
  );

  // Next-state for the wipe FSM and blink phase.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    k_d     = k_q;
    if (changed) begin
      cur_d = msg_san;
      if (bus.wipe_en_i) begin
        // A change during a wipe restarts it from the interrupted target.
        prev_d  = cur_q;
        k_d     = KW'(1);
        state_d = StWipe;
      end else begin
        state_d = StShow;
      end
    end else if ((state_q == StWipe) && wipe_tick) begin
      k_d = k_q + KW'(1);
      if (k_d == KW'(DIGITS)) begin
        state_d = StShow;
      end
    end

    phase_d = phase_q;
    if (blink_clr) begin
      phase_d = 1'b1;
    end else if (blink_tick) begin
      phase_d = ~phase_q;
    end
  end

  // Display image built from next-state so outputs lag the inputs by one edge.
  always_comb begin
    seg_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if ((state_d == StWipe) && ((d + int'(k_d)) < DIGITS)) begin
        seg_d[d] = bus.seg_i[prev_d][d];
      end else begin
        seg_d[d] = bus.seg_i[cur_d][d];
      end
      if ((bus.mode_i == MODE_BLINK) && !phase_d) begin
        seg_d[d] = BLANK;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StShow;
      cur_q   <= '0;
      prev_q  <= '0;
      k_q     <= '0;
      phase_q <= 1'b1;
      mode_q  <= MODE_STATIC;
      seg_q   <= {DIGITS{BLANK}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      k_q     <= k_d;
      phase_q <= phase_d;
      mode_q  <= bus.mode_i;
      seg_q   <= seg_d;
      busy_q  <= (state_d == StWipe);
    end
  end

  assign bus.seg_o  = seg_q;
  assign bus.busy_o = busy_q;

endmodule

// File: doc/seg7_msg_sequencer.md
# seg7_msg_sequencer

Parametrised successor to the 7-segment message selector. It picks one of `N_MSG` live message sources for a `DIGITS`-wide display and registers the result. It adds two sequential effects: a digit-by-digit wipe transition on a message change, and a blink mode. It sits between the game-control FSM, which drives `msg_i` and `mode_i`, and the HEX display pins.

## Interface
- `DIGITS`, 6, number of 7-segment digits; digit `DIGITS-1` is leftmost.
- `N_MSG`, 5, number of message sources; the `msg_t` encodings are the source indices.
- `WIPE_CYCLES`, 5_000_000, clock cycles between successive wipe steps (≥2).
- `BLINK_CYCLES`, 25_000_000, clock cycles per blink half-period (≥2).
- `BLANK`, 8'hFF, segment pattern for a dark digit (active-low segments).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `msg_i`  in  `$clog2(N_MSG)`  selected source index.
- `mode_i`  in  `seg_mode_t`  `MODE_STATIC` or `MODE_BLINK`.
- `wipe_en_i`  in  1  when 1, a message change uses the wipe transition; when 0, the change is immediate.
- `seg_i`  in  `[N_MSG][DIGITS]` x 8  live segment patterns of all sources.
- `seg_o`  out  `[DIGITS]` x 8  registered display segments.
- `busy_o`  out  1  high while a wipe is in progress.

## Operation
- **Index sanitising.** Any `msg_i ≥ N_MSG` is treated as index 0 (empty).
- **Live sources.** Sources are never latched. `seg_o` always reflects the current `seg_i` of the chosen index, so a running stopwatch keeps updating during a wipe and during blink.
- **Registers.** `cur_msg` holds the target index and `prev_msg` holds the outgoing index. `k` (0..`DIGITS`) is the count of revealed digits. `step_cnt` is the wipe prescaler. `blink_cnt` and `phase` drive blinking.
- **FSM state SHOW:**
  - Digit d shows `seg_i[cur_msg][d]`.
  - When the sanitised `msg_i` differs from `cur_msg` and `wipe_en_i`=1: set `prev_msg`←`cur_msg`, `cur_msg`←new index, `k`←1, `step_cnt`←0, then go to WIPE.
  - When the index differs and `wipe_en_i`=0: set `cur_msg`←new index and stay in SHOW.
- **FSM state WIPE:**
  - Digit d shows `seg_i[cur_msg][d]` when d ≥ `DIGITS-k`; otherwise it shows `seg_i[prev_msg][d]`.
  - `step_cnt` counts to `WIPE_CYCLES-1`, then wraps to 0 and increments `k`.
  - When `k` reaches `DIGITS`, return to SHOW.
- **Message change during WIPE.** The wipe restarts: `prev_msg`←`cur_msg` (the interrupted target), `cur_msg`←new index, `k`←1, `step_cnt`←0. When `wipe_en_i`=0, the change aborts the wipe and the FSM goes to SHOW with the new index.
- **`wipe_en_i` dropped mid-wipe.** No effect on the wipe already running.
- **Blink:**
  - `blink_cnt` counts 0..`BLINK_CYCLES-1`; at each wrap, `phase` toggles.
  - In `MODE_BLINK`, `phase`=0 forces every digit to `BLANK`. In `MODE_STATIC`, `phase` is ignored.
  - `blink_cnt`←0 and `phase`←1 (visible) on entry into `MODE_BLINK` and on every accepted message change.
  - Blink is applied after the wipe selection, so the two effects combine.
- **`busy_o`.** Equals (state == WIPE).
- **Reset values.** Every `seg_o` digit = `BLANK`; state SHOW; `cur_msg`=`prev_msg`=0; `k`=0; all counters 0; `phase`=1; `busy_o`=0.

## Timing
- All outputs are registered; latency is 1 cycle from the sampled inputs to `seg_o`.
- Message change sampled at edge t: at t+1, `seg_o` shows the new pattern on digit `DIGITS-1` only and `busy_o`=1. Each further digit appears every `WIPE_CYCLES` cycles after that.
- The last digit appears at t+1+(`DIGITS-1`)·`WIPE_CYCLES`; `busy_o` falls on that same cycle.
- Wipe disabled: the full new message appears at t+1 and `busy_o` stays 0.
- A source pattern change with an unchanged index appears on `seg_o` 1 cycle later.
- Reset asserted mid-wipe: outputs go to their reset values immediately (asynchronous). After release, the first edge loads `seg_o` from source `msg_i`.

## Structure
- `datatype_package` gains:
  - `seg_mode_t` enum (`MODE_STATIC`=0, `MODE_BLINK`=1).
  - `seg_seq_state_t` enum (SHOW, WIPE).
  - `SEG_BLANK` constant (8'hFF), used as the default of `BLANK`.
- The existing `msg_t` values must remain valid source indices.
- One sub-module, `seg7_tick_gen`: a parametrised prescaler (`DIV`, with a synchronous clear) emitting a 1-cycle tick at each wrap. It is instantiated twice, once for wipe steps and once for blink.

## Test plan
Bench parameters: `DIGITS`=6, `N_MSG`=5, `WIPE_CYCLES`=4, `BLINK_CYCLES`=8, with distinct constant patterns per source.
1. **Reset.** Assert reset with `msg_i`=2 -> every `seg_o` digit is 8'hFF and `busy_o`=0. Release reset -> the next cycle shows source 2 on all digits.
2. **Wipe.** With `wipe_en_i`=1, change 2→3 at edge t -> at t+1 digit 5 shows source 3 and digits 0–4 show source 2. Digits reveal at t+5, t+9, t+13, t+17; at t+21 all digits show source 3 and `busy_o` falls.
3. **Retarget mid-wipe.** Change 3→1 at t+6 of a 2→3 wipe -> at t+7 digit 5 shows source 1 and digits 0–4 show source 3. The full wipe completes at t+27.
4. **Immediate change and out-of-range index.** `wipe_en_i`=0 with `msg_i`=7 -> at t+1 all digits show source 0 and `busy_o` stays 0.
5. **Blink.** `MODE_BLINK` with a static message -> visible for 8 cycles, then 8'hFF on every digit for 8 cycles, repeating. A message change during the dark phase makes the display visible again at t+1.
6. **Live update and blink during wipe.** Change the `seg_i` content of the current source with the index unchanged -> `seg_o` follows 1 cycle later. Blink during a wipe -> dark phases blank every digit, and the wipe position still advances.
